// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserialiser with a configurable bit order, per-bit qualifier,
// a word-framing counter and a single-entry valid/ready output register with a sticky overrun flag.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_in,
    input  logic                     in_valid,
    input  logic                     clear,
    output logic [WIDTH-1:0]         p_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overrun,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sr_q,   sr_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             vld_q,  vld_d;
    logic             ovr_q,  ovr_d;

    logic [WIDTH-1:0] sr_shift;
    logic             drain;
    logic             word_done;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sr_shift = {sr_q[WIDTH-2:0], a_in};
        end else begin : g_lsb_first
            assign sr_shift = {a_in, sr_q[WIDTH-1:1]};
        end
    endgenerate

    assign drain     = vld_q & out_ready;
    assign word_done = in_valid & (cnt_q == CNT_LAST);

    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        pout_d = pout_q;
        vld_d  = vld_q;
        ovr_d  = ovr_q;

        if (clear) begin
            sr_d   = '0;
            cnt_d  = '0;
            pout_d = '0;
            vld_d  = 1'b0;
            ovr_d  = 1'b0;
        end else begin
            if (in_valid) begin
                sr_d  = sr_shift;
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
            end

            // A completed word may only land if the holding slot is empty or being emptied now.
            if (word_done) begin
                if (!vld_q || drain) begin
                    pout_d = sr_shift;
                    vld_d  = 1'b1;
                end else begin
                    ovr_d  = 1'b1;
                end
            end else if (drain) begin
                vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            pout_q <= '0;
            vld_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            pout_q <= pout_d;
            vld_q  <= vld_d;
            ovr_q  <= ovr_d;
        end
    end

    assign p_out     = pout_q;
    assign out_valid = vld_q;
    assign overrun   = ovr_q;
    assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: three instances (4-bit MSB-first, 4-bit LSB-first,
// 8-bit MSB-first) share one stimulus stream; expected values are hand-computed constants.
module tb_sipo_deserializer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic a_in = 1'b0;
    logic in_valid = 1'b0;
    logic clear = 1'b0;
    logic out_ready = 1'b1;

    logic [3:0] p4m, p4l;
    logic [7:0] p8;
    logic       v4m, v4l, v8;
    logic       o4m, o4l, o8;
    logic [1:0] c4m, c4l;
    logic [2:0] c8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u4m (
        .clk(clk), .reset(reset), .a_in(a_in), .in_valid(in_valid), .clear(clear),
        .p_out(p4m), .out_valid(v4m), .out_ready(out_ready), .overrun(o4m), .bit_cnt(c4m)
    );

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u4l (
        .clk(clk), .reset(reset), .a_in(a_in), .in_valid(in_valid), .clear(clear),
        .p_out(p4l), .out_valid(v4l), .out_ready(out_ready), .overrun(o4l), .bit_cnt(c4l)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u8 (
        .clk(clk), .reset(reset), .a_in(a_in), .in_valid(in_valid), .clear(clear),
        .p_out(p8), .out_valid(v8), .out_ready(out_ready), .overrun(o8), .bit_cnt(c8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one valid bit, let one edge take it, then return 1ns after that edge.
    task automatic send(input logic b);
        a_in     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_in     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #2 reset = 1'b0;
        #1;
        check("rst_p_out", p4m, 0);
        check("rst_out_valid", v4m, 0);
        check("rst_overrun", o4m, 0);
        check("rst_bit_cnt", c4m, 0);
        @(negedge clk) reset = 1'b1;
        idle(1);

        // Test 1/2: 1,0,1,1 back to back with out_ready high
        send(1'b1); check("t1_cnt1", c4m, 1);
        send(1'b0); check("t1_cnt2", c4m, 2);
        send(1'b1); check("t1_cnt3", c4m, 3); check("t1_vld_early", v4m, 0);
        send(1'b1); check("t1_cnt0", c4m, 0);
        check("t1_p_msb", p4m, 4'b1011);
        check("t1_vld", v4m, 1);
        check("t2_p_lsb", p4l, 4'b1101);
        check("t2_vld_lsb", v4l, 1);
        check("t1_cnt8", c8, 4);
        idle(1);
        check("t1_vld_drop", v4m, 0);

        // Test 2b: flush, then 8'hA5 MSB first; the 4-bit instance sees 1010 then 0101
        clear = 1'b1; idle(1); clear = 1'b0;
        check("clr_cnt8", c8, 0);
        send(1'b1); send(1'b0); send(1'b1); send(1'b0);
        check("t2_w4a", p4m, 4'b1010);
        send(1'b0); send(1'b1); send(1'b0); send(1'b1);
        check("t2_p8", p8, 8'hA5);
        check("t2_vld8", v8, 1);
        check("t2_w4b", p4m, 4'b0101);
        check("t2_ovr4_drain", o4m, 0);
        idle(1);

        // Test 3: 3-cycle gaps between bits
        send(1'b1); idle(3); check("t3_gap_cnt1", c4m, 1); check("t3_gap_vld1", v4m, 0);
        send(1'b0); idle(3); check("t3_gap_cnt2", c4m, 2);
        send(1'b1); idle(3); check("t3_gap_cnt3", c4m, 3); check("t3_gap_vld3", v4m, 0);
        send(1'b1);
        check("t3_p", p4m, 4'b1011);
        check("t3_vld", v4m, 1);
        idle(1);

        // Test 4: backpressure and overrun
        out_ready = 1'b0;
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        check("t4_p1", p4m, 4'b1011);
        check("t4_vld1", v4m, 1);
        check("t4_ovr0", o4m, 0);
        send(1'b0); send(1'b1); send(1'b1); send(1'b0);
        check("t4_p_hold", p4m, 4'b1011);
        check("t4_vld_hold", v4m, 1);
        check("t4_ovr1", o4m, 1);
        send(1'b0); send(1'b0); send(1'b1);
        out_ready = 1'b1;
        send(1'b1);
        check("t4_p_replace", p4m, 4'b0011);
        check("t4_vld_replace", v4m, 1);
        check("t4_ovr_sticky", o4m, 1);
        idle(1);
        check("t4_vld_drained", v4m, 0);
        check("t4_ovr_sticky2", o4m, 1);

        // Test 5: asynchronous reset mid-word
        send(1'b1); send(1'b0);
        check("t5_cnt_pre", c4m, 2);
        #3 reset = 1'b0;
        #1;
        check("t5_p", p4m, 0);
        check("t5_vld", v4m, 0);
        check("t5_ovr", o4m, 0);
        check("t5_cnt", c4m, 0);
        #2 reset = 1'b1;
        send(1'b0); send(1'b1); send(1'b1); send(1'b0);
        check("t5_p_after", p4m, 4'b0110);
        check("t5_vld_after", v4m, 1);

        // Test 6: clear on a completion edge with a pending word and overrun
        out_ready = 1'b0;
        send(1'b1); send(1'b1); send(1'b1); send(1'b1);
        check("t6_ovr_pend", o4m, 1);
        check("t6_vld_pend", v4m, 1);
        send(1'b1); send(1'b0); send(1'b0);
        clear = 1'b1;
        send(1'b1);
        clear = 1'b0;
        check("t6_p", p4m, 0);
        check("t6_vld", v4m, 0);
        check("t6_ovr", o4m, 0);
        check("t6_cnt", c4m, 0);
        check("t6_p_lsb", p4l, 0);
        idle(1);
        check("t6_no_word", v4m, 0);
        out_ready = 1'b1;
        send(1'b1); send(1'b1); send(1'b0); send(1'b0);
        check("t6_p_new", p4m, 4'b1100);
        check("t6_vld_new", v4m, 1);
        check("t6_p_new_lsb", p4l, 4'b0011);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Parametrised serial-in/parallel-out deserialiser. It is the successor to the fixed 4-bit SIPO shift register and adds:
- configurable word width and bit order;
- a per-bit input qualifier;
- a word-framing counter;
- a single-entry output holding register with valid/ready handshake and a sticky overrun flag.

It sits between a serial bit source and any word-wide consumer that may apply backpressure.

## Interface
Parameters:
- WIDTH, 4, word width in bits; legal range 2..32
- MSB_FIRST, 1, 1: first received bit lands in p_out[WIDTH-1]; 0: first received bit lands in p_out[0]

Ports:
- clk  input  1  rising-edge clock; single clock domain
- reset  input  1  asynchronous, active-low reset; asserting it (low) clears all state immediately
- a_in  input  1  serial data bit
- in_valid  input  1  a_in is sampled on a clk edge only when in_valid=1
- clear  input  1  synchronous flush; highest priority after reset
- p_out  output  WIDTH  assembled word (holding register)
- out_valid  output  1  p_out holds an unconsumed word
- out_ready  input  1  consumer accepts p_out on an edge where out_valid=1 and out_ready=1
- overrun  output  1  sticky: a completed word was dropped
- bit_cnt  output  $clog2(WIDTH)  number of bits of the current partial word received so far

## Operation
- Internal state:
  - shift register sr[WIDTH-1:0];
  - counter cnt (drives bit_cnt);
  - holding register p_out;
  - flags out_valid and overrun.
- Shift on each edge with in_valid=1:
  - MSB_FIRST=1: sr_next = {sr[WIDTH-2:0], a_in}.
  - MSB_FIRST=0: sr_next = {a_in, sr[WIDTH-1:1]}.
- With in_valid=0: sr and cnt hold. Gaps of any length between bits are legal.
- cnt increments per accepted bit and wraps WIDTH-1 -> 0. The edge that accepts the bit at cnt=WIDTH-1 completes a word; the completed word value is sr_next.
- drain = out_valid & out_ready.
- On word completion:
  - If out_valid=0 or drain=1: p_out <= sr_next and out_valid <= 1.
  - Otherwise: the word is discarded, p_out and out_valid are unchanged, and overrun <= 1.
- No completion and drain=1: out_valid <= 0. p_out keeps its last value, which is don't-care while out_valid=0.
- Clearing overrun: only clear or reset clears it. It stays set across further words.
- clear=1: sr, cnt, p_out, out_valid and overrun all go to 0 on that edge. clear overrides in_valid, word completion and drain.
- Reset (low): all of the above go to 0 asynchronously. On release, the first valid bit starts a fresh word at cnt=0. Reset mid-word discards the partial word.

## Timing
- Reset values: p_out=0, out_valid=0, overrun=0, bit_cnt=0.
- Latency: out_valid rises at the same clk edge that samples the WIDTH-th valid bit, so p_out is valid in the cycle after that bit is presented. There is no extra pipeline stage.
- Back-to-back throughput: one bit per cycle with out_ready tied high gives out_valid high for 1 cycle every WIDTH cycles.
- Simultaneous completion and drain on the same edge: the new word replaces the old, out_valid stays 1, and no overrun is raised.
- bit_cnt reads 0 immediately after a completion edge.
- out_valid/p_out must not change while out_valid=1 and out_ready=0, except via clear or reset.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
1. WIDTH=4, MSB_FIRST=1, out_ready=1; a_in 1,0,1,1 on 4 consecutive valid cycles -> after 4th edge p_out=4'b1011, out_valid high exactly 1 cycle, bit_cnt sequence 1,2,3,0.
2. WIDTH=4, MSB_FIRST=0, same stimulus -> p_out=4'b1101. WIDTH=8, MSB_FIRST=1, bits of 8'hA5 MSB first -> p_out=8'hA5.
3. Gapped input: WIDTH=4 bits 1,0,1,1 with in_valid low for 3 cycles between each -> bit_cnt holds during gaps, p_out=4'b1011, out_valid after 4th valid bit only.
4. Backpressure, WIDTH=4, out_ready=0:
   - word 4'b1011 then 4'b0110 -> p_out stays 4'b1011, out_valid=1, overrun=1.
   - Then raise out_ready coincident with the completion of word 4'b0011 -> p_out=4'b0011, out_valid=1, overrun stays 1.
5. Reset mid-word: after 2 valid bits, drive reset low between clock edges -> p_out=0, out_valid=0, overrun=0, bit_cnt=0 before the next edge. After release, bits 0,1,1,0 -> p_out=4'b0110.
6. clear on the completion edge of a word, with out_valid=1 and overrun=1 pending -> next cycle all outputs 0 and no word delivered. The following 4 valid bits produce a correct new word.
